// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST sequencer: FSM states and the test pattern.
package ram_bist_pkg;

    localparam int unsigned PAT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_WRI   = 3'd3,
        S_RDI   = 3'd4,
        S_DRAIN = 3'd5
    } state_e;

    // Address XOR seed, optionally inverted; callers truncate to the word width,
    // which keeps only the low min(ADDR_W, DATA_W) address bits.
    function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr,
                                             input logic [PAT_W-1:0] seed,
                                             input logic             inv);
        logic [PAT_W-1:0] p;
        p = addr ^ seed;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Compare side of the BIST: counts read mismatches and latches the first failing address.
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              cmp_valid_i,
    input  logic [DATA_W-1:0] expected_i,
    input  logic [ADDR_W-1:0] addr_d_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [ADDR_W+1:0] err_cnt_o,
    output logic              fail_valid_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic              mismatch_c_o
);

    localparam int unsigned CNT_W = ADDR_W + 2;

    logic [CNT_W-1:0]  err_cnt_q;
    logic              fail_valid_q;
    logic [ADDR_W-1:0] fail_addr_q;

    assign mismatch_c_o = cmp_valid_i && (mem_rdata_i != expected_i);

    // Saturating error count; first failing address is kept until the next clear.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
        end else if (mismatch_c_o) begin
            if (err_cnt_q != {CNT_W{1'b1}}) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            if (!fail_valid_q) begin
                fail_valid_q <= 1'b1;
                fail_addr_q  <= addr_d_i;
            end
        end
    end

    assign err_cnt_o    = err_cnt_q;
    assign fail_valid_o = fail_valid_q;
    assign fail_addr_o  = fail_addr_q;

endmodule

// File: rtl/ram_bist_controller.sv
// Four-phase write/verify BIST sequencer driving a single-port synchronous RAM.
module ram_bist_controller
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic              mem_cs_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W+1:0] err_cnt_o,
    output logic              fail_valid_o,
    output logic [ADDR_W-1:0] fail_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d, cs_q, cs_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              clear_c, last_c, mismatch_c, fail_valid_c;
    logic [ADDR_W-1:0] addr_nxt_c;

    assign last_c     = (addr_q == LAST_ADDR);
    assign addr_nxt_c = last_c ? '0 : addr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        clear_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_WR;
                    addr_d  = '0;
                    seed_d  = seed_i;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    clear_c = 1'b1;
                end
            end
            S_WR: begin
                addr_d = addr_nxt_c;
                if (last_c) state_d = S_RD;
            end
            S_RD: begin
                addr_d = addr_nxt_c;
                if (last_c) state_d = S_WRI;
            end
            S_WRI: begin
                addr_d = addr_nxt_c;
                if (last_c) state_d = S_RDI;
            end
            S_RDI: begin
                addr_d = addr_nxt_c;
                if (last_c) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // The final RDI compare lands in this cycle, so fold it into pass.
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = !(fail_valid_c || mismatch_c);
            end
            default: state_d = S_IDLE;
        endcase

        // RAM pins are registered from the next state so they line up with the address.
        we_d    = (state_d == S_WR) || (state_d == S_WRI);
        re_d    = (state_d == S_RD) || (state_d == S_RDI);
        cs_d    = we_d || re_d;
        wdata_d = we_d ? DATA_W'(pat(PAT_W'(addr_d), PAT_W'(seed_d), state_d == S_WRI)) : '0;

        // Expected word and address ride one cycle behind the read they belong to.
        cmp_valid_d = re_q;
        exp_d       = DATA_W'(pat(PAT_W'(addr_q), PAT_W'(seed_q), state_q == S_RDI));
        raddr_d     = addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            seed_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            cs_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            exp_q       <= '0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            seed_q      <= seed_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            cs_q        <= cs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
            raddr_q     <= raddr_d;
        end
    end

    ram_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_checker (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_c),
        .cmp_valid_i  (cmp_valid_q),
        .expected_i   (exp_q),
        .addr_d_i     (raddr_q),
        .mem_rdata_i  (mem_rdata_i),
        .err_cnt_o    (err_cnt_o),
        .fail_valid_o (fail_valid_c),
        .fail_addr_o  (fail_addr_o),
        .mismatch_c_o (mismatch_c)
    );

    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_we_o     = we_q;
    assign mem_re_o     = re_q;
    assign mem_cs_o     = cs_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign fail_valid_o = fail_valid_c;

endmodule
